// File: rtl/pc_sequencer.sv
// pc_sequencer: stall-aware program-counter controller for the 8-bit CPU.
// Define BRANCH_STATS_EN to build the saturating branch statistics counters.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef BRANCH_STATS_EN
   ,
   parameter int unsigned CNT_W    = 16
`endif
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             INSTR_VALID,
   input  logic             J,
   input  logic             BEQ,
   input  logic             BNE,
   input  logic             ZERO,
   input  logic [7:0]       OFFSET,
   input  logic             I_BUSYWAIT,
   input  logic             D_BUSYWAIT,
   output logic [31:0]      PC,
   output logic             PC_VALID,
   output logic             TAKEN,
   output logic             FLUSH
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] TAKEN_COUNT,
   output logic [CNT_W-1:0] BRANCH_COUNT
`endif
);

   localparam logic [1:0] ST_BOOT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_STALL  = 2'd2;
   localparam logic [1:0] ST_BUBBLE = 2'd3;

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [31:0] pc_r;
   logic [31:0] pc_nxt_s;
   logic        pc_valid_r;
   logic        pc_valid_nxt_s;
   logic        taken_r;
   logic        taken_nxt_s;
   logic        busy_s;
   logic        take_s;

   // Redirect target: sequential address plus sign-extended word offset, mod 2^32.
   function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                 input logic [7:0]  off);
      branch_target = pc + 32'd4 + {{22{off[7]}}, off, 2'b00};
   endfunction

   // Decode qualification shared by the FSM and the statistics.
   always_comb begin
      busy_s = I_BUSYWAIT | D_BUSYWAIT;
      take_s = INSTR_VALID & (J | (BEQ & ZERO) | (BNE & ~ZERO));
   end

   // Next-state and next-PC selection.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      pc_valid_nxt_s = pc_valid_r;
      taken_nxt_s    = 1'b0;
      case (state_r)
         ST_BOOT: begin
            state_nxt_s    = ST_RUN;
            pc_valid_nxt_s = 1'b1;
         end
         ST_RUN, ST_STALL: begin
            // Decode inputs only matter on the edge where both memories are free.
            if (busy_s) begin
               state_nxt_s    = ST_STALL;
               pc_valid_nxt_s = 1'b1;
            end else if (take_s) begin
               state_nxt_s    = ST_BUBBLE;
               pc_nxt_s       = branch_target(pc_r, OFFSET);
               pc_valid_nxt_s = 1'b0;
               taken_nxt_s    = 1'b1;
            end else begin
               state_nxt_s    = ST_RUN;
               pc_nxt_s       = pc_r + 32'd4;
               pc_valid_nxt_s = 1'b1;
            end
         end
         ST_BUBBLE: begin
            pc_valid_nxt_s = 1'b1;
            if (busy_s) begin
               state_nxt_s = ST_STALL;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s    = ST_BOOT;
            pc_nxt_s       = RESET_PC;
            pc_valid_nxt_s = 1'b0;
         end
      endcase
   end

   // Sequencer state registers with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_r    <= ST_BOOT;
         pc_r       <= RESET_PC;
         pc_valid_r <= 1'b0;
         taken_r    <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         pc_r       <= pc_nxt_s;
         pc_valid_r <= pc_valid_nxt_s;
         taken_r    <= taken_nxt_s;
      end
   end

   assign PC       = pc_r;
   assign PC_VALID = pc_valid_r;
   assign TAKEN    = taken_r;
   assign FLUSH    = taken_r;

`ifdef BRANCH_STATS_EN
   logic [CNT_W-1:0] taken_cnt_r;
   logic [CNT_W-1:0] branch_cnt_r;
   logic             commit_s;
   logic             is_branch_s;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1'b1);
      end
   endfunction

   // An instruction retires only on a free edge in RUN or STALL.
   always_comb begin
      commit_s    = ((state_r == ST_RUN) | (state_r == ST_STALL)) & ~busy_s;
      is_branch_s = INSTR_VALID & (J | BEQ | BNE);
   end

   // Saturating statistics counters.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         taken_cnt_r  <= '0;
         branch_cnt_r <= '0;
      end else begin
         if (commit_s && take_s) begin
            taken_cnt_r <= sat_inc(taken_cnt_r);
         end else begin
            taken_cnt_r <= taken_cnt_r;
         end
         if (commit_s && is_branch_s) begin
            branch_cnt_r <= sat_inc(branch_cnt_r);
         end else begin
            branch_cnt_r <= branch_cnt_r;
         end
      end
   end

   assign TAKEN_COUNT  = taken_cnt_r;
   assign BRANCH_COUNT = branch_cnt_r;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef BRANCH_STATS_EN
   localparam int TB_CNT_W = 3;
   localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;
`else
   localparam int CNT_MAX  = 1 << 30;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        INSTR_VALID, J, BEQ, BNE, ZERO, I_BUSYWAIT, D_BUSYWAIT;
   logic [7:0]  OFFSET;
   logic [31:0] PC;
   logic        PC_VALID, TAKEN, FLUSH;
`ifdef BRANCH_STATS_EN
   logic [TB_CNT_W-1:0] TAKEN_COUNT, BRANCH_COUNT;
`endif

   always #5 CLK = ~CLK;

   pc_sequencer #(
      .RESET_PC(RST_PC)
`ifdef BRANCH_STATS_EN
      , .CNT_W(TB_CNT_W)
`endif
   ) dut (
      .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID),
      .J(J), .BEQ(BEQ), .BNE(BNE), .ZERO(ZERO), .OFFSET(OFFSET),
      .I_BUSYWAIT(I_BUSYWAIT), .D_BUSYWAIT(D_BUSYWAIT),
      .PC(PC), .PC_VALID(PC_VALID), .TAKEN(TAKEN), .FLUSH(FLUSH)
`ifdef BRANCH_STATS_EN
      , .TAKEN_COUNT(TAKEN_COUNT), .BRANCH_COUNT(BRANCH_COUNT)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        taken;
      int          tc;
      int          bc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: what the sequencer must show after each edge.
   logic [31:0] m_pc;
   bit          m_valid, m_taken, m_boot, m_bubble;
   int          m_tc, m_bc;

   function automatic int sat(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_edge(input bit rst, input bit iv, input bit j, input bit beq,
                             input bit bne, input bit z, input logic [7:0] off, input bit busy);
      longint t;
      bit     tk;
      if (!rst) begin
         m_pc = RST_PC; m_valid = 1'b0; m_taken = 1'b0;
         m_boot = 1'b1; m_bubble = 1'b0; m_tc = 0; m_bc = 0;
      end else if (m_boot) begin
         m_boot = 1'b0; m_valid = 1'b1; m_taken = 1'b0;
      end else if (m_bubble) begin
         m_bubble = 1'b0; m_valid = 1'b1; m_taken = 1'b0;
      end else if (busy) begin
         m_valid = 1'b1; m_taken = 1'b0;
      end else begin
         tk = iv && (j || (beq && z) || (bne && !z));
         if (iv && (j || beq || bne)) m_bc = sat(m_bc + 1);
         if (tk) begin
            t = longint'(m_pc) + 4 + 4 * longint'($signed(off));
            m_pc = t[31:0]; m_taken = 1'b1; m_valid = 1'b0; m_bubble = 1'b1;
            m_tc = sat(m_tc + 1);
         end else begin
            t = longint'(m_pc) + 4;
            m_pc = t[31:0]; m_taken = 1'b0; m_valid = 1'b1;
         end
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then record the expectation.
   task automatic step(input bit rst, input bit iv, input bit j, input bit beq, input bit bne,
                       input bit z, input logic [7:0] off, input bit ib, input bit db);
      exp_t e;
      RESET = rst; INSTR_VALID = iv; J = j; BEQ = beq; BNE = bne; ZERO = z;
      OFFSET = off; I_BUSYWAIT = ib; D_BUSYWAIT = db;
      @(posedge CLK); #1;
      model_edge(rst, iv, j, beq, bne, z, off, ib | db);
      e.pc = m_pc; e.valid = m_valid; e.taken = m_taken; e.tc = m_tc; e.bc = m_bc;
      exp_q.push_back(e);
   endtask

   task automatic nop();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic run_to(input logic [31:0] target);
      int n = 0;
      while (!(m_pc == target && !m_boot && !m_bubble) && n < 100) begin
         nop();
         n++;
      end
      check("run_to_reached", {31'd0, (n < 100)}, 32'd1);
   endtask

   // Monitor: compare every presented output cycle against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pc", PC, e.pc);
            check("pc_valid", {31'd0, PC_VALID}, {31'd0, e.valid});
            check("taken", {31'd0, TAKEN}, {31'd0, e.taken});
            check("flush", {31'd0, FLUSH}, {31'd0, e.taken});
`ifdef BRANCH_STATS_EN
            check("taken_count", 32'(TAKEN_COUNT), e.tc);
            check("branch_count", 32'(BRANCH_COUNT), e.bc);
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      RESET = 1'b0; INSTR_VALID = 1'b0; J = 1'b0; BEQ = 1'b0; BNE = 1'b0;
      ZERO = 1'b0; OFFSET = 8'h00; I_BUSYWAIT = 1'b0; D_BUSYWAIT = 1'b0;

      // Reset then free run.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("reset_valid", {31'd0, PC_VALID}, 32'd0);
      nop(); check("boot_pc", PC, 32'h0);
      nop(); check("run_pc4", PC, 32'h4);
      nop(); check("run_pc8", PC, 32'h8);
      nop(); check("run_pc12", PC, 32'hC);

      // Taken BEQ with negative offset.
      run_to(32'h10);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
      check("beq_target", PC, 32'hC);
      check("beq_taken", {31'd0, TAKEN}, 32'd1);
      nop(); check("bubble_hold", PC, 32'hC);
      nop(); check("after_bubble", PC, 32'h10);

      // Not-taken BNE then J.
      run_to(32'h20);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
      check("bne_not_taken", PC, 32'h24);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
      check("j_target", PC, 32'h34);
      nop();

      // Stall across a held J.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1);
         check("stall_freeze", PC, 32'h34);
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
      check("stall_redirect", PC, 32'h44);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h03, 1'b1, 1'b0);
      nop(); nop();

      // Wrap through zero.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      nop();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0);
      check("wrap_target", PC, 32'hFFFF_FFFC);
      nop();
      nop(); check("wrap_zero", PC, 32'h0);

      // Reset while stalled and while in a bubble.
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("stall_reset_pc", PC, RST_PC);
      check("stall_reset_valid", {31'd0, PC_VALID}, 32'd0);
      nop(); nop();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 0);
      check("bubble_reset_pc", PC, RST_PC);
      nop(); nop();

      // Five branches, three taken.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0); nop();
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0); nop();
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0); nop();
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
      check("stats_branch5", 32'(BRANCH_COUNT), 32'd5);
      check("stats_taken3", 32'(TAKEN_COUNT), 32'd3);
`endif

      // Random traffic, including rare resets and invalid decode cycles.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 99) != 0), $urandom_range(0, 3) != 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
              8'($urandom), $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
      end

      @(negedge CLK); #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
